imm_ext_arbiter: RTL and testbench
==================================

# imm_ext_arbiter

Shares one 8-to-16-bit immediate extension unit between two requesters: instruction decode (port 0) and branch-offset unit (port 1). Each request is an 8-bit immediate plus a mode bit selecting sign or zero extension. The block grants round-robin, registers one result with the winner's ID, and holds it under output backpressure. It sits between the decode/branch stages and the ALU operand mux.

## Interface
Parameters:
- IN_W, 8, immediate input width
- OUT_W, 16, extended result width; must be greater than IN_W

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 (decode) has a request
- req0_data  in  IN_W  requester 0 immediate
- req0_signed  in  1  1 = sign-extend, 0 = zero-extend
- req0_ready  out  1  requester 0 request accepted this cycle
- req1_valid / req1_data / req1_signed / req1_ready  same as above, for requester 1 (branch)
- out_valid  out  1  out_data/out_id hold a result
- out_data  out  OUT_W  extended immediate
- out_id  out  1  ID of the requester that produced out_data
- out_ready  in  1  consumer takes the result this cycle

## Operation
- Transfer rule: a transfer occurs on any port where valid and ready are both 1 at a rising edge.
- Result slot: a single output register. It is free when out_valid = 0 or out_ready = 1 (the block accepts and drains in the same cycle).
- Grant:
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ last_grant wins.
  - last_grant updates only on an accepted transfer.
- Ready signals:
  - reqN_ready = grant_N AND slot free.
  - Combinational from valids, last_grant, out_valid and out_ready.
  - Never asserted on both ports in the same cycle.
  - Never asserted for a requester whose valid is 0.
- Extension:
  - out_data[IN_W-1:0] = data.
  - Upper OUT_W-IN_W bits are all data[IN_W-1] if signed = 1, otherwise 0.
- State (2-state FSM): EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY → FULL on accept.
  - FULL → FULL on accept + drain.
  - FULL → EMPTY on drain without accept.
  - FULL with out_ready = 0: out_data and out_id stay stable, and both readies are 0.
- Requesters must hold valid, data and signed stable until ready. The block does not check this.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_id = 0, last_grant = 1 (so requester 0 wins the first contested cycle). reqN_ready = 0 while reset = 1.
- Latency: a request accepted at edge N has out_valid = 1 and its data visible after edge N. The combinational extension feeds the output register, with no extra stage.
- Throughput: one result per cycle when out_ready is held at 1. Under continuous contention, grants alternate 0,1,0,1.
- Reset mid-operation: a held result is dropped (out_valid = 0 on the next cycle). Requests presented during reset are not accepted.
- Simultaneous drain + accept: the new result replaces the old one at the same edge, with no bubble.

## Structure
- Package imm_ext_pkg holds:
  - IN_W/OUT_W defaults
  - REQ_DECODE = 1'b0 and REQ_BRANCH = 1'b1 ID constants
  - the EMPTY/FULL state encoding
- Sub-module imm_extend: purely combinational (data, signed) → OUT_W result. The arbiter instantiates it once, on the granted request's muxed data.
- Everything else (grant logic, last_grant, output register) stays in imm_ext_arbiter.

## Test plan
- Reset: hold reset with both valids = 1 → readies 0, and out_valid/out_data/out_id = 0. After release, the first contested cycle grants requester 0.
- Extension modes, out_ready = 1:
  - req0 0x30 signed → 0x0030
  - req0 0x80 signed → 0xFF80
  - req0 0xC0 zero → 0x00C0
  - req0 0x50 signed → 0x0050
  - each result appears one cycle after acceptance, with out_id = 0.
- Contention: both requesters valid for 4 cycles (req0 0x11 signed, req1 0xF0 signed), out_ready = 1 → out_id sequence 0,1,0,1 with data 0x0011, 0xFFF0, alternating. Exactly one ready per cycle.
- Backpressure: result 0xFF80 held with out_ready = 0 for 3 cycles → out_data stable and both readies 0. Then raise out_ready with req1 valid (0x7F zero) → drain and accept at the same edge, next out_data 0x007F, out_id 1.
- Single requester: only req1 valid for 3 back-to-back requests → all granted to 1, no idle cycles.
- Reset mid-operation: assert reset while out_valid = 1 and out_ready = 0 → out_valid = 0 after the edge, the result is lost, and last_grant returns to 1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared constants and state encoding for the immediate-extension arbiter.
package imm_ext_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 16;

  localparam logic REQ_DECODE = 1'b0;
  localparam logic REQ_BRANCH = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extension: sign- or zero-fills the upper bits.
module imm_extend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  data,
  input  logic             sign_ext,
  output logic [OUT_W-1:0] result
);

  logic fill;

  assign fill   = sign_ext & data[IN_W-1];
  assign result = {{(OUT_W-IN_W){fill}}, data};

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extension unit between decode
// (port 0) and branch (port 1), with a single backpressured result register.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  input  logic             req0_signed,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  input  logic             req1_signed,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready
);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             slot_free;
  logic             grant0, grant1;
  logic             accept;
  logic [IN_W-1:0]  sel_data_p0;
  logic             sel_signed_p0;
  logic [OUT_W-1:0] ext_p0;
  logic [OUT_W-1:0] data_p1;
  logic             id_p1;

  // A full slot frees up in the same cycle the consumer drains it.
  assign slot_free = (state == EMPTY) | out_ready;

  assign grant0 = req0_valid & (~req1_valid | (last_grant == REQ_BRANCH));
  assign grant1 = req1_valid & (~req0_valid | (last_grant == REQ_DECODE));

  assign req0_ready = grant0 & slot_free & ~reset;
  assign req1_ready = grant1 & slot_free & ~reset;
  assign accept     = req0_ready | req1_ready;

  assign sel_data_p0   = grant1 ? req1_data   : req0_data;
  assign sel_signed_p0 = grant1 ? req1_signed : req0_signed;

  imm_extend #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_extend (
    .data     (sel_data_p0),
    .sign_ext (sel_signed_p0),
    .result   (ext_p0)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (!accept && out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  // p0 -> p1: extended result registered with the winner's ID
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1    <= '0;
      id_p1      <= REQ_DECODE;
      last_grant <= REQ_BRANCH;
    end else if (accept) begin
      data_p1    <= ext_p0;
      id_p1      <= req1_ready;
      last_grant <= req1_ready;
    end
  end

  assign out_data = data_p1;
  assign out_id   = id_p1;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter with a behavioural reference model.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_signed = 1'b0, req0_ready;
  logic [7:0]  req0_data = 8'h00;
  logic        req1_valid = 1'b0, req1_signed = 1'b0, req1_ready;
  logic [7:0]  req1_data = 8'h00;
  logic        out_valid, out_id;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic        m_valid = 1'b0;
  logic [15:0] m_data  = 16'h0000;
  logic        m_id    = 1'b0;
  logic        m_last  = 1'b1;

  imm_ext_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_signed (req0_signed),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_signed (req1_signed),
    .req1_ready  (req1_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Value semantics: treat the byte as a signed or unsigned integer, keep 16 bits.
  function automatic logic [15:0] model_ext(input logic [7:0] d, input logic s);
    int v;
    v = int'(d);
    if (s && v >= 128) v = v - 256;
    return v[15:0];
  endfunction

  function automatic int winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int  w;
    bit  free;
    free = !m_valid || out_ready;
    w    = winner(req0_valid, req1_valid, m_last);
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 16'h0000;
      m_id    = 1'b0;
      m_last  = 1'b1;
    end else if (free && w >= 0) begin
      m_valid = 1'b1;
      m_data  = (w == 0) ? model_ext(req0_data, req0_signed) : model_ext(req1_data, req1_signed);
      m_id    = (w == 1);
      m_last  = (w == 1);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    int  w;
    bit  free, e0, e1;
    if (cmp_en) begin
      free = !m_valid || out_ready;
      w    = winner(req0_valid, req1_valid, m_last);
      e0   = !reset && free && (w == 0);
      e1   = !reset && free && (w == 1);
      chk("model_req0_ready", req0_ready, e0);
      chk("model_req1_ready", req1_ready, e1);
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("model_out_data", out_data, m_data);
        chk("model_out_id", out_id, m_id);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic s0,
                       input logic v1, input logic [7:0] d1, input logic s1,
                       input logic ordy);
    req0_valid = v0; req0_data = d0; req0_signed = s0;
    req1_valid = v1; req1_data = d1; req1_signed = s1;
    out_ready  = ordy;
  endtask

  logic [7:0]  ext_in  [4] = '{8'h30, 8'h80, 8'hC0, 8'h50};
  logic        ext_sg  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] ext_exp [4] = '{16'h0030, 16'hFF80, 16'h00C0, 16'h0050};
  logic [7:0]  one_in  [3] = '{8'h01, 8'h81, 8'h7E};
  logic [15:0] one_exp [3] = '{16'h0001, 16'hFF81, 16'h007E};
  logic [15:0] con_exp [4] = '{16'h0011, 16'hFFF0, 16'h0011, 16'hFFF0};

  initial begin
    drive(1, 8'hAA, 0, 1, 8'h55, 0, 0);
    reset = 1'b1;
    nxt();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_id", out_id, 0);

    nxt();
    reset = 1'b0;
    drive(1, 8'hAA, 0, 1, 8'h55, 0, 1);
    @(negedge clk);
    chk("first_contest_r0", req0_ready, 1);
    chk("first_contest_r1", req1_ready, 0);

    for (int i = 0; i < 4; i++) begin
      nxt();
      drive(1, ext_in[i], ext_sg[i], 0, 8'h00, 0, 1);
      @(negedge clk);
      chk("ext_ready", req0_ready, 1);
      if (i == 0) begin
        chk("contest_data", out_data, 16'h00AA);
        chk("contest_id", out_id, 0);
      end else begin
        chk("ext_data", out_data, ext_exp[i-1]);
        chk("ext_id", out_id, 0);
      end
    end
    nxt();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("ext_data_last", out_data, 16'h0050);
    chk("ext_valid_last", out_valid, 1);

    for (int i = 0; i < 3; i++) begin
      nxt();
      drive(0, 8'h00, 0, 1, one_in[i], 1, 1);
      @(negedge clk);
      chk("single_r1", req1_ready, 1);
      if (i > 0) begin
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, one_exp[i-1]);
        chk("single_id", out_id, 1);
      end
    end

    for (int k = 0; k < 4; k++) begin
      nxt();
      drive(1, 8'h11, 1, 1, 8'hF0, 1, 1);
      @(negedge clk);
      chk("contend_r0", req0_ready, (k % 2 == 0));
      chk("contend_r1", req1_ready, (k % 2 == 1));
      if (k == 0) begin
        chk("single_data_last", out_data, 16'h007E);
        chk("single_id_last", out_id, 1);
      end else begin
        chk("contend_data", out_data, con_exp[k-1]);
        chk("contend_id", out_id, (k - 1) % 2);
      end
    end

    nxt();
    drive(1, 8'h80, 1, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("contend_data_last", out_data, 16'hFFF0);
    chk("contend_id_last", out_id, 1);

    for (int j = 0; j < 3; j++) begin
      nxt();
      drive(0, 8'h00, 0, 1, 8'h7F, 0, 0);
      @(negedge clk);
      chk("bp_data", out_data, 16'hFF80);
      chk("bp_r0", req0_ready, 0);
      chk("bp_r1", req1_ready, 0);
    end
    nxt();
    drive(0, 8'h00, 0, 1, 8'h7F, 0, 1);
    @(negedge clk);
    chk("bp_release_r1", req1_ready, 1);
    nxt();
    drive(1, 8'h22, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("bp_new_data", out_data, 16'h007F);
    chk("bp_new_id", out_id, 1);
    chk("bp_new_valid", out_valid, 1);

    nxt();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk("mid_held_data", out_data, 16'h0022);
    chk("mid_held_valid", out_valid, 1);
    nxt();
    reset = 1'b1;
    drive(1, 8'h33, 0, 1, 8'h44, 0, 0);
    @(negedge clk);
    chk("mid_rst_r0", req0_ready, 0);
    chk("mid_rst_r1", req1_ready, 0);
    nxt();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 16'h0000);
    nxt();
    reset = 1'b0;
    drive(1, 8'h33, 0, 1, 8'h44, 0, 1);
    @(negedge clk);
    chk("post_rst_r0", req0_ready, 1);
    chk("post_rst_r1", req1_ready, 0);
    nxt();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("post_rst_data", out_data, 16'h0033);
    chk("post_rst_id", out_id, 0);

    nxt();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
